vpu_readback_unit: RTL
======================

Name: vpu_readback_unit

Overview:
- Return path from the VPU to the CPU. On a CPU read request for an object number, it resolves the object's storage address through the object unit and reads the 144-bit object record from video memory.
- It then unpacks the record into the nine 16-bit CPU readback fields and strobes VPU_data_we for one cycle.
- It sits beside the matrix unit on the video memory read port and is the producer of the CPU's VPU_V0..VPU_RO / VPU_data_we inputs.

Parameters:
- MEM_LAT, 1: cycles from the mem_rd_en sample edge to mem_obj_in valid.
- ADDR_TIMEOUT, 15: maximum LOOKUP cycles to wait for addr_vld before declaring the object absent.
- MAX_OBJ, 32: number of valid object numbers; rd_obj_num >= MAX_OBJ is an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  single-cycle read request from the CPU
- rd_obj_num  in  5  object number to read; sampled with rd_req
- ref_addr  out  1  address-lookup request to the object unit
- obj_num_out  out  5  object number presented to the object unit
- addr_vld  in  1  object unit: addr is valid for obj_num_out
- addr  in  5  object unit: storage address of the object
- mem_writing  in  1  matrix unit currently owns the memory port
- mem_rd_en  out  1  video memory read enable
- mem_addr  out  5  video memory read address
- mem_obj_in  in  144  video memory read data
- VPU_V0..VPU_V7  out  16 each  unpacked vertex fields to the CPU
- VPU_RO  out  16  unpacked attribute/rotation field to the CPU
- VPU_data_we  out  1  one-cycle strobe: VPU_* fields valid, CPU latches them
- rd_busy  out  1  high whenever state != IDLE
- rd_err  out  1  one-cycle strobe: request failed

Behaviour:
- Reset: all outputs 0, all VPU_* fields 0, state IDLE. Reset asserted mid-operation aborts immediately: no VPU_data_we, no rd_err, and mem_rd_en and ref_addr drop asynchronously.
- States: IDLE, LOOKUP, READ, WAIT, DELIVER, ERROR.
- IDLE:
  - rd_req=1 with rd_obj_num < MAX_OBJ: latch the object number, clear the timeout counter, go to LOOKUP.
  - rd_obj_num >= MAX_OBJ: go to ERROR.
  - rd_req while not IDLE is ignored; there is no queue.
- LOOKUP:
  - ref_addr=1 and obj_num_out=latched number every cycle.
  - addr_vld=1: latch addr, go to READ.
  - Otherwise increment the counter. When the counter reaches ADDR_TIMEOUT, go to ERROR; exactly ADDR_TIMEOUT ref_addr cycles are issued.
- READ:
  - mem_writing=1: hold, mem_rd_en=0.
  - mem_writing=0: mem_rd_en=1 and mem_addr=latched addr for exactly one cycle, then go to WAIT.
- WAIT:
  - Count MAX(MEM_LAT,1) cycles. mem_writing is ignored.
  - On the edge where mem_obj_in is valid, register the unpack: VPU_V0=[143:128], VPU_V1=[127:112], VPU_V2=[111:96], VPU_V3=[95:80], VPU_V4=[79:64], VPU_V5=[63:48], VPU_V6=[47:32], VPU_V7=[31:16], VPU_RO=[15:0].
  - Go to DELIVER.
- DELIVER: VPU_data_we=1 for one cycle, then IDLE.
- ERROR: rd_err=1 for one cycle, VPU_* unchanged, VPU_data_we=0, then IDLE.
- VPU_* fields hold their value until the next successful DELIVER; they are never cleared by an error.
- Latency: rd_req sampled at edge N, addr_vld high in the first LOOKUP cycle, mem_writing low → VPU_data_we high in cycle N+3+MEM_LAT (N+4 at default). Each cycle of addr_vld delay or mem_writing stall adds one cycle.
- rd_busy goes high the cycle after rd_req is accepted and stays high through the DELIVER/ERROR cycle.
- A new rd_req in the cycle after DELIVER/ERROR (state IDLE) is accepted.
- Only one of VPU_data_we and rd_err is ever high per request.

Test Plan:
- Object 3 stored at addr 7, record 0x0001_0002_..._0009 (V0=1 … RO=9), addr_vld in the first LOOKUP cycle, mem_writing=0 → mem_rd_en/mem_addr=7 in cycle N+2; VPU_data_we single pulse in cycle N+4; VPU_V0=0x0001 … VPU_RO=0x0009.
- Same request with mem_writing=1 for 5 cycles on entering READ → mem_rd_en held low 5 cycles; VPU_data_we at N+9.
- addr_vld never asserted → ref_addr high for exactly 15 cycles, rd_err pulse once, VPU_* retain previous values, VPU_data_we stays 0.
- Second rd_req pulses during LOOKUP and WAIT → ignored: single mem_rd_en, single VPU_data_we. Back-to-back request issued the cycle after DELIVER → completes normally.
- rst_n asserted while in WAIT → all outputs 0 immediately; no VPU_data_we after reset release; a new request afterwards completes normally.
- MEM_LAT=3 build, object 31 at addr 0 → VPU_data_we at N+6; fields match the memory record.

Source files
------------

// File: rtl/vpu_readback_unit.sv
// CPU readback path: resolves an object's storage address through the object unit,
// fetches its 144-bit record from video memory and delivers it as nine 16-bit fields.
module vpu_readback_unit #(
  parameter int MEM_LAT      = 1,
  parameter int ADDR_TIMEOUT = 15,
  parameter int MAX_OBJ      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rd_req,
  input  logic [4:0]   rd_obj_num,
  output logic         ref_addr,
  output logic [4:0]   obj_num_out,
  input  logic         addr_vld,
  input  logic [4:0]   addr,
  input  logic         mem_writing,
  output logic         mem_rd_en,
  output logic [4:0]   mem_addr,
  input  logic [143:0] mem_obj_in,
  output logic [15:0]  VPU_V0,
  output logic [15:0]  VPU_V1,
  output logic [15:0]  VPU_V2,
  output logic [15:0]  VPU_V3,
  output logic [15:0]  VPU_V4,
  output logic [15:0]  VPU_V5,
  output logic [15:0]  VPU_V6,
  output logic [15:0]  VPU_V7,
  output logic [15:0]  VPU_RO,
  output logic         VPU_data_we,
  output logic         rd_busy,
  output logic         rd_err
);

  localparam int LAT     = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam int CNT_MAX = (ADDR_TIMEOUT > LAT) ? ADDR_TIMEOUT : LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ADDR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, READ, WAIT, DELIVER, ERROR
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [4:0]       obj_p0, obj_d;
  logic [4:0]       addr_p1, addr_d;
  logic [143:0]     rec_p2;
  logic             rec_ld;

  function automatic logic obj_in_range(input logic [4:0] n);
    logic [31:0] w;
    w = 32'(n);
    return (w < 32'(MAX_OBJ));
  endfunction

  // Record layout: V0 in the top 16 bits down to RO in the bottom 16 bits.
  function automatic logic [15:0] field(input logic [143:0] r, input int idx);
    return r[143-16*idx -: 16];
  endfunction

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    obj_d   = obj_p0;
    addr_d  = addr_p1;
    rec_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          if (obj_in_range(rd_obj_num)) begin
            obj_d   = rd_obj_num;
            cnt_d   = '0;
            state_d = LOOKUP;
          end else begin
            state_d = ERROR;
          end
        end
      end
      LOOKUP: begin
        if (addr_vld) begin
          addr_d  = addr;
          state_d = READ;
        end else if (cnt == TO_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      READ: begin
        if (!mem_writing) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // The counter is reused here to line up with the memory read latency.
        if (cnt == LAT_LAST) begin
          rec_ld  = 1'b1;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DELIVER: state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: control state, latched lookup/read operands and delivered record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      obj_p0  <= '0;
      addr_p1 <= '0;
      rec_p2  <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      obj_p0  <= obj_d;
      addr_p1 <= addr_d;
      if (rec_ld) rec_p2 <= mem_obj_in;
    end
  end

  always_comb begin
    ref_addr    = (state == LOOKUP);
    obj_num_out = ref_addr ? obj_p0 : 5'd0;
    mem_rd_en   = (state == READ) && !mem_writing;
    mem_addr    = mem_rd_en ? addr_p1 : 5'd0;
    VPU_data_we = (state == DELIVER);
    rd_err      = (state == ERROR);
    rd_busy     = (state != IDLE);
  end

  assign VPU_V0 = field(rec_p2, 0);
  assign VPU_V1 = field(rec_p2, 1);
  assign VPU_V2 = field(rec_p2, 2);
  assign VPU_V3 = field(rec_p2, 3);
  assign VPU_V4 = field(rec_p2, 4);
  assign VPU_V5 = field(rec_p2, 5);
  assign VPU_V6 = field(rec_p2, 6);
  assign VPU_V7 = field(rec_p2, 7);
  assign VPU_RO = field(rec_p2, 8);

endmodule
